// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the MUX4 round-robin arbiter.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the arbiter driving a MUX4 select.
interface mux4_rr_arbiter_if;
  import mux4_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic               owner_timeout;

  modport master (
    output req,
    input  gnt, sel, busy, owner_timeout
  );

  modport slave (
    input  req,
    output gnt, sel, busy, owner_timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin pick: first set request after 'last', wrapping 3->0.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // k=3 wraps back to 'last' itself, giving it lowest priority
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = last + SEL_W'(k + 1);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one MUX4 among four requesters, with optional hold-time limit.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_cnt_w_check
    $error("CNT_W too narrow: 2**CNT_W must exceed MAX_HOLD");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               to_q, to_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   last_q, last_d;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   pick_last;
  logic               owner_req;
  logic               timeout_hit;

  // During a grant the owner is the rotation origin, so one picker serves both states
  assign pick_last   = (state_q == GRANT) ? sel_q : last_q;
  assign owner_req   = bus.req[sel_q];
  assign timeout_hit = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = onehot4(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          last_d = sel_q;
          if (pick_any) begin
            gnt_d = onehot4(pick_idx);
            sel_d = pick_idx;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (timeout_hit) begin
          // owner's bit is still set, so the pick always succeeds (self if alone)
          to_d   = 1'b1;
          last_d = sel_q;
          gnt_d  = onehot4(pick_idx);
          sel_d  = pick_idx;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.sel           = sel_q;
  assign bus.busy          = busy_q;
  assign bus.owner_timeout = to_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter (MAX_HOLD=3) driving a behavioural MUX4.
module tb_mux4_rr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
    logic       y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] mux_d = 4'b1001;  // A=1, B=0, C=0, D=1
  logic y;

  int unsigned tests = 0;
  int unsigned fails = 0;
  exp_t exp_q[$];

  mux4_rr_arbiter_if arb_if ();

  mux4_rr_arbiter #(.MAX_HOLD(3), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_if)
  );

  assign y = mux_d[arb_if.sel];

  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic [3:0] r,
                      input logic [3:0] g, input logic [1:0] s,
                      input logic b, input logic t);
    exp_t e;
    @(negedge clk);
    rst_n      = rn;
    arb_if.req = r;
    e.gnt  = g;
    e.sel  = s;
    e.busy = b;
    e.to   = t;
    e.y    = mux_d[s];
    exp_q.push_back(e);
  endtask

  // Monitor: compares DUT outputs after each edge against the queued expectation
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.gnt  = arb_if.gnt;
        a.sel  = arb_if.sel;
        a.busy = arb_if.busy;
        a.to   = arb_if.owner_timeout;
        a.y    = y;
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got gnt=%b sel=%0d busy=%b to=%b y=%b, want gnt=%b sel=%0d busy=%b to=%b y=%b",
                   $time, a.gnt, a.sel, a.busy, a.to, a.y, e.gnt, e.sel, e.busy, e.to, e.y);
        end
        tests++;
        if (!$onehot0(arb_if.gnt) || (arb_if.busy !== (arb_if.gnt != 4'b0000))) begin
          fails++;
          $display("FAIL invariant_onehot_busy @%0t: got gnt=%b busy=%b, want onehot0 gnt and busy==|gnt",
                   $time, arb_if.gnt, arb_if.busy);
        end
        if (arb_if.busy === 1'b1) begin
          tests++;
          if (arb_if.gnt[arb_if.sel] !== 1'b1) begin
            fails++;
            $display("FAIL invariant_gnt_sel @%0t: got gnt=%b sel=%0d, want gnt[sel]=1",
                     $time, arb_if.gnt, arb_if.sel);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arb_if.req = 4'b0000;

    // reset, then a single request and drop
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    // round-robin fairness with back-to-back hand-off
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b1, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // timeout alternation between two requesters
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // sole requester: re-granted on timeout, busy never drops
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

    // mid-grant reset, then requester 1 wins since last=3
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    // drop on the timeout edge counts as a drop: no pulse
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    // MUX4 integration: A and D both 1
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
